// File: rtl/pll_ce_pkg.sv
// Shared definitions for the pll_ce_gen clock-enable generator: limits, the
// settle-counter width, the accumulator word and an increment calculator.
package pll_ce_pkg;

  localparam int MAX_CH    = 16;
  localparam int CNT_W     = 16;
  localparam int MAX_ACC_W = 32;

  typedef logic [MAX_ACC_W-1:0] acc_t;

  typedef enum logic [1:0] {
    LK_IDLE,
    LK_SETTLE,
    LK_RUN
  } lock_state_e;

  // Increment word giving tgt_hz from ref_hz with an acc_w-bit accumulator.
  function automatic acc_t calc_inc(input longint unsigned ref_hz,
                                    input longint unsigned tgt_hz,
                                    input int unsigned     acc_w);
    longint unsigned num;
    num = tgt_hz << acc_w;
    if (ref_hz == 0) return '0;
    return acc_t'(num / ref_hz);
  endfunction

endpackage

// File: rtl/pll_ce_chan.sv
// One fractional enable channel: phase accumulator whose carry is the enable.
// With PLL_CE_GEN_SQ_EN defined, a toggle flop turns the enables into a square wave.
module pll_ce_chan
  import pll_ce_pkg::*;
#(
  parameter int ACC_W = 32
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             en,
  input  logic             sync,
  input  logic [ACC_W-1:0] inc,
  output logic             ce,
  output logic             sq
);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ce_q, ce_d;
  logic [ACC_W:0]   sum;

  // Disabled or sync both park the phase at zero; sync wins over a carry.
  always_comb begin
    sum  = {1'b0, acc_q} + {1'b0, inc};
    acc_d = acc_q;
    ce_d  = 1'b0;
    if (!en || sync) begin
      acc_d = '0;
    end else begin
      {ce_d, acc_d} = sum;
    end
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      ce_q  <= 1'b0;
    end else begin
      acc_q <= acc_d;
      ce_q  <= ce_d;
    end
  end

  assign ce = ce_q;

`ifdef PLL_CE_GEN_SQ_EN
  logic sq_q, sq_d;

  always_comb begin
    sq_d = sq_q ^ ce_d;
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      sq_q <= 1'b0;
    end else begin
      sq_q <= sq_d;
    end
  end

  assign sq = sq_q;
`else
  assign sq = 1'b0;
`endif

endmodule

// File: rtl/pll_ce_gen.sv
// N-channel fractional clock-enable generator gated by a synchronised, settled
// PLL lock. Optional square-wave outputs are built when PLL_CE_GEN_SQ_EN is defined.
module pll_ce_gen
  import pll_ce_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int ACC_W    = 32,
  parameter int LOCK_DLY = 16
) (
  input  logic                    refclk,
  input  logic                    rst,
  input  logic                    locked_in,
  input  logic                    sync,
  input  logic [NUM_CH*ACC_W-1:0] inc,
  output logic [NUM_CH-1:0]       ce,
  output logic [NUM_CH-1:0]       sq,
  output logic                    run
);

  localparam logic [CNT_W-1:0] LOCK_DLY_C = CNT_W'(LOCK_DLY);

  logic [1:0]       lk_sync_q, lk_sync_d;
  logic             lk_s;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  lock_state_e      state_q, state_d;
  logic             chan_en;

  assign lk_s = lk_sync_q[1];

  // run reflects the counter value being loaded, so it changes on the same
  // edge as the counter and lock loss is seen after exactly three edges.
  always_comb begin
    lk_sync_d = {lk_sync_q[0], locked_in};
    cnt_d     = cnt_q;
    state_d   = state_q;
    if (!lk_s) begin
      cnt_d   = '0;
      state_d = LK_IDLE;
    end else begin
      if (cnt_q != LOCK_DLY_C) cnt_d = cnt_q + 1'b1;
      state_d = (cnt_d == LOCK_DLY_C) ? LK_RUN : LK_SETTLE;
    end
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      lk_sync_q <= '0;
      cnt_q     <= '0;
      state_q   <= LK_IDLE;
    end else begin
      lk_sync_q <= lk_sync_d;
      cnt_q     <= cnt_d;
      state_q   <= state_d;
    end
  end

  assign run = (state_q == LK_RUN);

  // Accumulate only while running now and still running after this edge,
  // which forces ce low on the very edge that run falls.
  assign chan_en = run && (state_d == LK_RUN);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    pll_ce_chan #(
      .ACC_W(ACC_W)
    ) u_chan (
      .refclk(refclk),
      .rst   (rst),
      .en    (chan_en),
      .sync  (sync),
      .inc   (inc[i*ACC_W +: ACC_W]),
      .ce    (ce[i]),
      .sq    (sq[i])
    );
  end

endmodule

// File: tb/tb_pll_ce_gen.sv
// Directed and randomized bench for pll_ce_gen (NUM_CH=2, ACC_W=8, LOCK_DLY=4)
// against an arithmetic phase/lock-history model.
module tb_pll_ce_gen;
  import pll_ce_pkg::*;

  localparam int NUM_CH   = 2;
  localparam int ACC_W    = 8;
  localparam int LOCK_DLY = 4;
  localparam int MODV     = 1 << ACC_W;

  logic                    refclk = 1'b0;
  logic                    rst;
  logic                    locked_in;
  logic                    sync;
  logic [NUM_CH*ACC_W-1:0] inc;
  logic [NUM_CH-1:0]       ce;
  logic [NUM_CH-1:0]       sq;
  logic                    run;

  int vectors = 0;
  int errors  = 0;

  // reference model state
  int                m_acc[NUM_CH];
  logic [NUM_CH-1:0] m_ce;
  logic [NUM_CH-1:0] m_sq;
  logic              m_run;
  int                streak;
  int                s_prev1, s_prev2;

  pll_ce_gen #(
    .NUM_CH  (NUM_CH),
    .ACC_W   (ACC_W),
    .LOCK_DLY(LOCK_DLY)
  ) dut (
    .refclk   (refclk),
    .rst      (rst),
    .locked_in(locked_in),
    .sync     (sync),
    .inc      (inc),
    .ce       (ce),
    .sq       (sq),
    .run      (run)
  );

  always #5 refclk = ~refclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int inc_of(input int ch);
    return int'(inc[ch*ACC_W +: ACC_W]);
  endfunction

  task automatic set_inc(input int v0, input int v1);
    inc[0*ACC_W +: ACC_W] = ACC_W'(v0);
    inc[1*ACC_W +: ACC_W] = ACC_W'(v1);
  endtask

  task automatic model_reset();
    streak  = 0;
    s_prev1 = 0;
    s_prev2 = 0;
    m_run   = 1'b0;
    m_ce    = '0;
    m_sq    = '0;
    foreach (m_acc[c]) m_acc[c] = 0;
  endtask

  // run after edge k needs locked_in sampled high on the LOCK_DLY edges
  // ending two edges before k (two synchroniser stages).
  task automatic step();
    logic run_after, en;
    int   sum;
    run_after = (s_prev2 >= LOCK_DLY);
    en        = m_run && run_after;
    for (int c = 0; c < NUM_CH; c++) begin
      if (!en || sync) begin
        m_acc[c] = 0;
        m_ce[c]  = 1'b0;
      end else begin
        sum      = m_acc[c] + inc_of(c);
        m_ce[c]  = (sum >= MODV);
        m_acc[c] = sum % MODV;
      end
`ifdef PLL_CE_GEN_SQ_EN
      if (m_ce[c]) m_sq[c] = ~m_sq[c];
`endif
    end
    m_run   = run_after;
    s_prev2 = s_prev1;
    streak  = locked_in ? ((streak < 100000) ? streak + 1 : streak) : 0;
    s_prev1 = streak;
    @(posedge refclk);
    #1;
    chk("run", 32'(run), 32'(m_run));
    chk("ce", 32'(ce), 32'(m_ce));
    chk("sq", 32'(sq), 32'(m_sq));
  endtask

  initial begin
    int first_run, first_ce0, cnt0, cnt1, n, guard;
    rst       = 1'b1;
    locked_in = 1'b0;
    sync      = 1'b0;
    inc       = '0;
    model_reset();
    #1;
    chk("reset_ce", 32'(ce), 32'd0);
    chk("reset_sq", 32'(sq), 32'd0);
    chk("reset_run", 32'(run), 32'd0);
    repeat (2) @(posedge refclk);
    #1;
    rst = 1'b0;

    // lock-up with integer and fractional channels
    set_inc(int'(calc_inc(64'd1024, 64'd256, ACC_W)), 96);
    locked_in = 1'b1;
    first_run = 0;
    first_ce0 = 0;
    cnt0      = 0;
    cnt1      = 0;
    for (int i = 1; i <= 22; i++) begin
      step();
      if (run && first_run == 0) first_run = i;
      if (ce[0] && first_ce0 == 0) first_ce0 = i;
      if (i >= 7 && i <= 14) begin
        cnt0 += int'(ce[0]);
        cnt1 += int'(ce[1]);
      end
    end
    chk("lockup_edge", 32'(first_run), 32'd6);
    chk("first_ce0_edge", 32'(first_ce0), 32'd10);
    chk("ce0_per8", 32'(cnt0), 32'd2);
    chk("ce1_per8", 32'(cnt1), 32'd3);

    // sync on a cycle where channel 0 would fire
    guard = 0;
    while ((m_acc[0] + inc_of(0)) < MODV && guard < 16) begin
      step();
      guard++;
    end
    chk("sync_found", 32'(guard < 16), 32'd1);
    sync = 1'b1;
    step();
    sync = 1'b0;
    chk("sync_ce0", 32'(ce[0]), 32'd0);
    n = 0;
    for (int i = 1; i <= 8 && n == 0; i++) begin
      step();
      if (ce[0]) n = i;
    end
    chk("sync_next_ce0", 32'(n), 32'd4);

    // lock loss and re-acquire
    locked_in = 1'b0;
    repeat (3) step();
    chk("lockloss_run", 32'(run), 32'd0);
    chk("lockloss_ce", 32'(ce), 32'd0);
    repeat (2) step();
    locked_in = 1'b1;
    n = 0;
    for (int i = 1; i <= 20 && n == 0; i++) begin
      step();
      if (run) n = i;
    end
    chk("relock_edge", 32'(n), 32'd6);

    // zero increment: never fires
    set_inc(0, 0);
    cnt0 = 0;
    repeat (1000) begin
      step();
      cnt0 += int'(ce[0]) + int'(ce[1]);
    end
    chk("inc0_pulses", 32'(cnt0), 32'd0);

    // full-scale increment from a fresh run
    locked_in = 1'b0;
    repeat (5) step();
    set_inc(255, 255);
    locked_in = 1'b1;
    guard = 0;
    while (!run && guard < 20) begin
      step();
      guard++;
    end
    step();
    chk("inc255_edge1", 32'(ce), 32'd0);
    cnt0 = 0;
    repeat (20) begin
      step();
      cnt0 += int'(ce == 2'b11);
    end
    chk("inc255_pulses", 32'(cnt0), 32'd20);

    // randomized increments, sync strobes and lock glitches
    for (int i = 0; i < 400; i++) begin
      if (i % 16 == 0) set_inc($urandom_range(0, MODV - 1), $urandom_range(0, MODV - 1));
      sync      = ($urandom_range(0, 15) == 0);
      locked_in = ($urandom_range(0, 59) != 0);
      step();
    end
    sync = 1'b0;

    // asynchronous reset mid-run
    locked_in = 1'b1;
    set_inc(64, 200);
    repeat (20) step();
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_ce", 32'(ce), 32'd0);
    chk("async_rst_sq", 32'(sq), 32'd0);
    chk("async_rst_run", 32'(run), 32'd0);
    model_reset();
    @(posedge refclk);
    #1;
    rst = 1'b0;
    repeat (16) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
